// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays out a change amount one coin at a time using a
// greedy largest-coin-first search over nine denominations, while keeping
// a per-denomination stock count. The FSM state is exported on dbg_state.
//
// Handshake: change_req is a single-cycle request that is accepted only
// while IDLE. change_busy stays high from the accepting edge until DONE
// exits. change_done pulses for one cycle at the end of every payout.
// Requests that arrive while busy are dropped, not queued.
module vm_change_dispenser #(
  parameter int PRICE_WIDTH  = 16,
  parameter int PULSE_CYCLES = 1000,
  parameter int GAP_CYCLES   = 500,
  parameter int INIT_STOCK   = 10
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   change_req,
  input  logic [PRICE_WIDTH-1:0] change_amount,
  output logic                   change_busy,
  output logic                   change_done,
  output logic                   change_short,
  output logic [PRICE_WIDTH-1:0] remaining_amount,
  output logic [8:0]             change_motors,
  input  logic                   stock_wr,
  input  logic [3:0]             stock_sel,
  input  logic [7:0]             stock_data,
  output logic [7:0]             stock_level,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       STOCK_RST  = 8'(INIT_STOCK);

  // Fixed denomination table, index 0 is the smallest coin.
  function automatic logic [PRICE_WIDTH-1:0] coin_value(input logic [3:0] idx);
    logic [PRICE_WIDTH-1:0] v;
    case (idx)
      4'd0:    v = PRICE_WIDTH'(1);
      4'd1:    v = PRICE_WIDTH'(2);
      4'd2:    v = PRICE_WIDTH'(5);
      4'd3:    v = PRICE_WIDTH'(10);
      4'd4:    v = PRICE_WIDTH'(20);
      4'd5:    v = PRICE_WIDTH'(50);
      4'd6:    v = PRICE_WIDTH'(100);
      4'd7:    v = PRICE_WIDTH'(500);
      4'd8:    v = PRICE_WIDTH'(2000);
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t                 state_q, state_d;
  logic [PRICE_WIDTH-1:0] remaining_q, remaining_d;
  logic                   short_q, short_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [8:0]             motors_q, motors_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [8:0][7:0]        stock_q, stock_d;

  logic                   sel_found;
  logic [3:0]             sel_idx;

  // Greedy search: the ascending scan leaves the highest eligible coin selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (stock_q[i] != 8'd0 && coin_value(4'(i)) <= remaining_q) begin
        sel_found = 1'b1;
        sel_idx   = 4'(i);
      end
    end
  end

  // Next-state and datapath updates for the payout FSM.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    motors_d    = motors_q;
    cnt_d       = cnt_q;
    stock_d     = stock_q;
    case (state_q)
      S_IDLE: begin
        // A stock load and a request in the same cycle both land; SELECT
        // then runs against the freshly loaded count.
        if (stock_wr && stock_sel <= 4'd8) begin
          stock_d[stock_sel] = stock_data;
        end
        if (change_req) begin
          short_d     = 1'b0;
          busy_d      = 1'b1;
          remaining_d = change_amount;
          state_d     = (change_amount != '0) ? S_SELECT : S_DONE;
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          motors_d           = 9'(1) << sel_idx;
          remaining_d        = remaining_q - coin_value(sel_idx);
          stock_d[sel_idx]   = stock_q[sel_idx] - 8'd1;
          cnt_d              = PULSE_LOAD;
          state_d            = S_PULSE;
        end else begin
          short_d = (remaining_q != '0);
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          motors_d = 9'd0;
          cnt_d    = GAP_LOAD;
          state_d  = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        // First DONE cycle raises the registered done pulse; the edge after
        // the pulse drops busy and returns to IDLE.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        motors_d = 9'd0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State register; reset wins over everything, dropping motors on the same edge.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      short_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      motors_q    <= 9'd0;
      cnt_q       <= '0;
      stock_q     <= {9{STOCK_RST}};
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      motors_q    <= motors_d;
      cnt_q       <= cnt_d;
      stock_q     <= stock_d;
    end
  end

  assign change_busy      = busy_q;
  assign change_done      = done_q;
  assign change_short     = short_q;
  assign remaining_amount = remaining_q;
  assign change_motors    = motors_q;
  assign stock_level      = (stock_sel <= 4'd8) ? stock_q[stock_sel] : 8'd0;
  assign dbg_state        = state_q;

endmodule
